// File: rtl/data_memory_responder.sv
// Data-memory responder: single-port word RAM with LOAD / STORE_PRELOAD / STORE / NOP requests.
// Define BYTE_ENABLE_WRITE_EN to write STOREs with byte enables instead of preload read-modify-write.
module data_memory_responder #(
  parameter int unsigned WORD_ADDR_WIDTH = 10,
  parameter string       INIT_FILE       = ""
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_mode,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error
);

  localparam int unsigned Depth = 2 ** WORD_ADDR_WIDTH;

  localparam logic [1:0] ModeLoad    = 2'd0;
  localparam logic [1:0] ModePreload = 2'd1;
  localparam logic [1:0] ModeStore   = 2'd2;
  localparam logic [1:0] ModeNop     = 2'd3;

  typedef enum logic [1:0] {StIdle, StAccess, StRespond} state_e;

  state_e                     state_q;
  logic [1:0]                 mode_q;
  logic [2:0]                 funct3_q;
  logic [31:0]                addr_q;
  logic [31:0]                wdata_q;
  logic                       rsp_valid_q;
  logic [31:0]                rsp_rdata_q;
  logic                       rsp_error_q;

  logic [31:0]                mem [Depth];
  logic [31:0]                ram_rdata;
  logic [WORD_ADDR_WIDTH-1:0] req_waddr;
  logic [WORD_ADDR_WIDTH-1:0] acc_waddr;

  logic                       addr_high_err;
  logic                       misalign_err;
  logic                       funct3_err;
  logic                       preload_miss;
  logic                       req_error;

  logic [31:0]                lane_data;
  logic [3:0]                 lane_be;
  logic [31:0]                write_data;
  logic [3:0]                 write_be;
  logic                       mem_we;
  logic [31:0]                load_shifted;
  logic [31:0]                load_data;

  assign req_waddr = req_addr[WORD_ADDR_WIDTH+1:2];
  assign acc_waddr = addr_q[WORD_ADDR_WIDTH+1:2];

  assign req_ready = (state_q == StIdle);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = rsp_error_q;

`ifndef BYTE_ENABLE_WRITE_EN
  logic                       preload_valid_q;
  logic [31:0]                preload_data_q;
  logic [WORD_ADDR_WIDTH-1:0] preload_waddr_q;

  assign preload_miss = (req_mode == ModeStore) &&
                        !(preload_valid_q && (preload_waddr_q == req_waddr));
`else
  assign preload_miss = 1'b0;
`endif

  // Request checks are evaluated against the live request while in IDLE.
  always_comb begin
    addr_high_err = (req_addr >> (WORD_ADDR_WIDTH + 2)) != 32'd0;
    misalign_err  = ((req_funct3[1:0] == 2'd1) && req_addr[0]) ||
                    ((req_funct3[1:0] == 2'd2) && (req_addr[1:0] != 2'd0));
    if (req_mode == ModeLoad) begin
      funct3_err = (req_funct3 == 3'd3) || (req_funct3 == 3'd6) || (req_funct3 == 3'd7);
    end else begin
      funct3_err = (req_funct3 > 3'd2);
    end
    req_error = (req_mode != ModeNop) &&
                (addr_high_err || misalign_err || funct3_err || preload_miss);
  end

  // Replicate store data across lanes and select the enabled bytes.
  always_comb begin
    lane_data = wdata_q;
    lane_be   = 4'hf;
    unique case (funct3_q[1:0])
      2'd0: begin
        lane_data = {4{wdata_q[7:0]}};
        lane_be   = 4'b0001 << addr_q[1:0];
      end
      2'd1: begin
        lane_data = {2{wdata_q[15:0]}};
        lane_be   = addr_q[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        lane_data = wdata_q;
        lane_be   = 4'hf;
      end
    endcase
  end

`ifndef BYTE_ENABLE_WRITE_EN
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      write_data[8*i +: 8] = lane_be[i] ? lane_data[8*i +: 8] : preload_data_q[8*i +: 8];
    end
    write_be = 4'hf;
  end
`else
  assign write_data = lane_data;
  assign write_be   = lane_be;
`endif

  always_comb begin
    load_shifted = ram_rdata >> {addr_q[1:0], 3'b000};
    unique case (funct3_q)
      3'd0:    load_data = {{24{load_shifted[7]}}, load_shifted[7:0]};
      3'd1:    load_data = {{16{load_shifted[15]}}, load_shifted[15:0]};
      3'd4:    load_data = {24'd0, load_shifted[7:0]};
      3'd5:    load_data = {16'd0, load_shifted[15:0]};
      default: load_data = ram_rdata;
    endcase
  end

  // A reset landing on the ACCESS edge must not commit the store.
  assign mem_we = (state_q == StAccess) && (mode_q == ModeStore) && !reset;

  always_ff @(posedge clock) begin
    ram_rdata <= mem[req_waddr];
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (write_be[i]) begin
          mem[acc_waddr][8*i +: 8] <= write_data[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= StIdle;
      mode_q          <= ModeNop;
      funct3_q        <= 3'd0;
      addr_q          <= 32'd0;
      wdata_q         <= 32'd0;
      rsp_valid_q     <= 1'b0;
      rsp_rdata_q     <= 32'd0;
      rsp_error_q     <= 1'b0;
`ifndef BYTE_ENABLE_WRITE_EN
      preload_valid_q <= 1'b0;
      preload_data_q  <= 32'd0;
      preload_waddr_q <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            mode_q   <= req_mode;
            funct3_q <= req_funct3;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
`ifndef BYTE_ENABLE_WRITE_EN
            // Any STORE consumes the preload, including one that is rejected.
            if (req_mode == ModeStore) begin
              preload_valid_q <= 1'b0;
            end
`endif
            if ((req_mode == ModeNop) || req_error) begin
              state_q     <= StRespond;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= 32'd0;
              rsp_error_q <= req_error;
            end else begin
              state_q <= StAccess;
            end
          end
        end
        StAccess: begin
          state_q     <= StRespond;
          rsp_valid_q <= 1'b1;
          rsp_error_q <= 1'b0;
          rsp_rdata_q <= (mode_q == ModeLoad) ? load_data : 32'd0;
`ifndef BYTE_ENABLE_WRITE_EN
          if (mode_q == ModePreload) begin
            preload_valid_q <= 1'b1;
            preload_data_q  <= ram_rdata;
            preload_waddr_q <= acc_waddr;
          end
`endif
        end
        StRespond: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Randomized self-checking bench for data_memory_responder against a byte-level memory model.
module tb_data_memory_responder;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_mode = 2'd3;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_error;

  int checks = 0;
  int failures = 0;

  // Reference state: first 32 words of RAM plus the preload buffer.
  logic [31:0] mem_m [32];
  logic        pl_valid = 1'b0;
  int unsigned pl_word = 0;
  logic [31:0] pl_data = 32'd0;

  data_memory_responder dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_mode  (req_mode),
    .req_funct3(req_funct3),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_error (rsp_error)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned acc_size(input logic [2:0] f3);
    return 1 << (f3 % 4);
  endfunction

  function automatic logic model_err(input logic [1:0] m, input logic [2:0] f3,
                                     input logic [31:0] a);
    if (m == 2'd3) return 1'b0;
    if (a >= 32'h1000) return 1'b1;
    if (m == 2'd0 && (f3 == 3 || f3 == 6 || f3 == 7)) return 1'b1;
    if (m != 2'd0 && f3 > 2) return 1'b1;
    if (a % acc_size(f3) != 0) return 1'b1;
    if (m == 2'd2 && !(pl_valid && pl_word == a / 4)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] w;
    logic [31:0] v;
    w = mem_m[a / 4];
    v = w >> (8 * (a % 4));
    case (f3)
      3'd0: begin v = v & 32'hFF;   if (v >= 32'h80)   v = v | 32'hFFFF_FF00; end
      3'd1: begin v = v & 32'hFFFF; if (v >= 32'h8000) v = v | 32'hFFFF_0000; end
      3'd4: v = v & 32'hFF;
      3'd5: v = v & 32'hFFFF;
      default: v = w;
    endcase
    return v;
  endfunction

  // One full transaction: present, wait for response (bounded), then consume it.
  task automatic xact(input logic [1:0] m, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, output logic [31:0] rd, output logic er,
                      output int lat);
    req_mode = m; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 8) begin
      @(posedge clock); #1;
      lat++;
    end
    rd = rsp_rdata;
    er = rsp_error;
    rsp_ready = 1'b1;
    @(posedge clock); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic run(input string tag, input logic [1:0] m, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd, output logic [31:0] rd);
    logic        e_err;
    logic [31:0] e_rd;
    logic        er;
    int          lat;
    logic [31:0] w;
    e_err = model_err(m, f3, a);
    e_rd  = (m == 2'd0 && !e_err) ? model_load(f3, a) : 32'd0;
    chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    xact(m, f3, a, wd, rd, er, lat);
    chk({tag, "_rdata"}, rd, e_rd);
    chk({tag, "_error"}, {31'd0, er}, {31'd0, e_err});
    chk({tag, "_latency"}, lat, (e_err || m == 2'd3) ? 32'd1 : 32'd2);
    if (m == 2'd1 && !e_err) begin
      pl_valid = 1'b1;
      pl_word  = a / 4;
      pl_data  = mem_m[a / 4];
    end
    if (m == 2'd2) begin
      if (!e_err) begin
        w = pl_data;
        for (int i = 0; i < int'(acc_size(f3)); i++) begin
          w[8 * (int'(a % 4) + i) +: 8] = wd[8 * i +: 8];
        end
        mem_m[a / 4] = w;
      end
      pl_valid = 1'b0;
    end
  endtask

  task automatic store_word(input string tag, input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] rd;
    run({tag, "_pre"}, 2'd1, 3'd2, a, 32'd0, rd);
    run({tag, "_sw"}, 2'd2, 3'd2, a, wd, rd);
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] a;
    logic [31:0] held;
    logic [2:0]  f3;

    repeat (2) @(posedge clock);
    #1;
    chk("reset_ready", {31'd0, req_ready}, 32'd1);
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_rdata", rsp_rdata, 32'd0);
    chk("reset_error", {31'd0, rsp_error}, 32'd0);
    reset = 1'b0;
    #1;

    for (int i = 0; i < 32; i++) store_word("init", 32'(i * 4), $urandom);

    // Directed: word store / load round trip.
    store_word("t1", 32'h10, 32'hDEAD_BEEF);
    run("t1_lw", 2'd0, 3'd2, 32'h10, 32'd0, rd);
    chk("t1_lw_value", rd, 32'hDEAD_BEEF);

    // Directed: lane extraction and sign handling.
    store_word("t2", 32'h20, 32'h8070_6050);
    run("t2_lb", 2'd0, 3'd0, 32'h23, 32'd0, rd);
    chk("t2_lb_value", rd, 32'hFFFF_FF80);
    run("t2_lbu", 2'd0, 3'd4, 32'h23, 32'd0, rd);
    chk("t2_lbu_value", rd, 32'h0000_0080);
    run("t2_lh", 2'd0, 3'd1, 32'h22, 32'd0, rd);
    chk("t2_lh_value", rd, 32'hFFFF_8070);

    // Directed: sub-word read-modify-write.
    run("t3_pre", 2'd1, 3'd2, 32'h20, 32'd0, rd);
    run("t3_sb", 2'd2, 3'd0, 32'h21, 32'h0000_0011, rd);
    run("t3_lw", 2'd0, 3'd2, 32'h20, 32'd0, rd);
    chk("t3_lw_value", rd, 32'h8070_1150);

    // Directed: preload misses.
    run("t4_nopre", 2'd2, 3'd2, 32'h30, 32'h1111_1111, rd);
    run("t4_pre34", 2'd1, 3'd2, 32'h34, 32'd0, rd);
    run("t4_wrong", 2'd2, 3'd2, 32'h30, 32'h2222_2222, rd);
    run("t4_lw", 2'd0, 3'd2, 32'h30, 32'd0, rd);

    // Directed: alignment, range and NOP.
    run("t5_lh41", 2'd0, 3'd1, 32'h41, 32'd0, rd);
    run("t5_lw42", 2'd0, 3'd2, 32'h42, 32'd0, rd);
    run("t5_range", 2'd0, 3'd2, 32'h0000_4000, 32'd0, rd);
    run("t5_nop", 2'd3, 3'd0, 32'h0, 32'hFFFF_FFFF, rd);

    // Directed: response held under backpressure.
    held = model_load(3'd2, 32'h20);
    req_mode = 2'd0; req_funct3 = 3'd2; req_addr = 32'h20; req_valid = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(posedge clock); #1;
    for (int i = 0; i < 5; i++) begin
      chk("t6_hold_valid", {31'd0, rsp_valid}, 32'd1);
      chk("t6_hold_rdata", rsp_rdata, held);
      chk("t6_hold_ready", {31'd0, req_ready}, 32'd0);
      @(posedge clock); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clock); #1;
    rsp_ready = 1'b0;

    // Directed: reset during the ACCESS cycle of a STORE.
    run("t6_pre", 2'd1, 3'd2, 32'h50, 32'd0, rd);
    req_mode = 2'd2; req_funct3 = 3'd2; req_addr = 32'h50; req_wdata = 32'h1234_5678;
    req_valid = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    pl_valid = 1'b0;
    chk("t6_rst_ready", {31'd0, req_ready}, 32'd1);
    chk("t6_rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("t6_rst_rdata", rsp_rdata, 32'd0);
    chk("t6_rst_error", {31'd0, rsp_error}, 32'd0);
    run("t6_after", 2'd0, 3'd2, 32'h50, 32'd0, rd);
    run("t6_store_after", 2'd2, 3'd2, 32'h50, 32'hCAFE_F00D, rd);

    // Randomized traffic; preload/store pairs keep the success path exercised.
    for (int n = 0; n < 150; n++) begin
      a  = 32'($urandom_range(0, 127));
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) a = 32'h1000 << $urandom_range(0, 4);
      if ($urandom_range(0, 1) == 1) begin
        run("rnd_pre", 2'd1, 3'd2, a & 32'h7C, 32'd0, rd);
        run("rnd_st", 2'd2, 3'($urandom_range(0, 2)), a, $urandom, rd);
      end else begin
        run("rnd_any", 2'($urandom_range(0, 3)), f3, a, $urandom, rd);
      end
    end

    for (int i = 0; i < 32; i++) run("final_lw", 2'd0, 3'd2, 32'(i * 4), 32'd0, rd);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
